// File: rtl/rv_arb_pkg.sv
// rv_arb_pkg: shared state type, default parameters and index helper for rv_rr_arbiter
package rv_arb_pkg;
   typedef enum logic {IDLE, LOCK} state_t;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_NUM_REQ = 4;
   function automatic int wrap_add(int a, int b, int n);
      return (a + b >= n) ? a + b - n : a + b;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set bit of req searching upward from ptr, modulo N
module rr_pick
   import rv_arb_pkg::*;
#(
   parameter int N = DEF_NUM_REQ,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);
   // Scan from farthest to nearest so the nearest match is the last write.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[IW'(wrap_add(int'(ptr), i, N))]) idx = IW'(wrap_add(int'(ptr), i, N));
   end
   assign any = |req;
endmodule

// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter: packet-locked round-robin merge of NUM_REQ valid/ready streams into one
module rv_rr_arbiter
   import rv_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]            in_val,
   input  logic [NUM_REQ-1:0]            in_last,
   output logic [NUM_REQ-1:0]            in_rdy,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [IW-1:0]                 out_id,
   output logic                          out_val,
   input  logic                          out_rdy,
   output logic                          busy
);
   state_t state, state_nxt;
   logic [IW-1:0] grant, rr_ptr, pick_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic pick_any, open, accept, last_beat;
   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req(in_val),
      .ptr(rr_ptr),
      .idx(pick_idx),
      .any(pick_any)
   );
   assign open = !out_val || out_rdy;
   assign in_rdy = (state == LOCK && open) ? NUM_REQ'(1) << grant : '0;
   assign accept = state == LOCK && in_val[grant] && open;
   assign last_beat = accept && in_last[grant];
   assign busy = state == LOCK;
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant == IW'(i)) sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
   end
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (pick_any ? LOCK : IDLE) : (last_beat ? IDLE : LOCK);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // The winner's successor becomes the search origin, so the winner ranks last next time.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         grant <= '0;
         rr_ptr <= '0;
      end else begin
         if (state == IDLE && pick_any) grant <= pick_idx;
         if (last_beat) rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_data <= '0;
         out_last <= 1'b0;
         out_id <= '0;
         out_val <= 1'b0;
      end else if (accept) begin
         out_data <= sel_data;
         out_last <= in_last[grant];
         out_id <= grant;
         out_val <= 1'b1;
      end else if (out_rdy) out_val <= 1'b0;
endmodule

// File: tb/tb_rv_rr_arbiter.sv
// tb_rv_rr_arbiter: randomized check of rv_rr_arbiter against a packet-level reference model
module tb_rv_rr_arbiter;
   localparam int N = 4;
   localparam int DW = 8;
   typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
   typedef struct packed {logic [DW-1:0] d; logic l; logic [1:0] id;} obeat_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [N*DW-1:0] in_data;
   logic [N-1:0] in_val, in_last, in_rdy;
   logic [DW-1:0] out_data;
   logic [1:0] out_id;
   logic out_last, out_val, out_rdy, busy;
   logic [3*DW-1:0] in_data3;
   logic [2:0] in_val3, in_last3, in_rdy3;
   logic [DW-1:0] out_data3;
   logic [1:0] out_id3;
   logic out_last3, out_val3, out_rdy3, busy3;
   beat_t src [N][$];
   obeat_t oq [$];
   int ids [$];
   int ids3 [$];
   int vectors = 0, errs = 0, cyc = 0, t_val = -1, t_out = -1, vprob = 100, rprob = 100, n_acc = 0;
   bit m_lock;
   int m_own, m_ptr;
   rv_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_val(in_val), .in_last(in_last),
      .in_rdy(in_rdy), .out_data(out_data), .out_last(out_last), .out_id(out_id),
      .out_val(out_val), .out_rdy(out_rdy), .busy(busy)
   );
   rv_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_val(in_val3), .in_last(in_last3),
      .in_rdy(in_rdy3), .out_data(out_data3), .out_last(out_last3), .out_id(out_id3),
      .out_val(out_val3), .out_rdy(out_rdy3), .busy(busy3)
   );
   always #5 clk = ~clk;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic model_reset;
      m_lock = 1'b0;
      m_own = 0;
      m_ptr = 0;
      oq.delete();
      for (int r = 0; r < N; r++) src[r].delete();
   endtask
   task automatic add_pkt(int r, int len, int base);
      for (int i = 0; i < len; i++) src[r].push_back(beat_t'{DW'(base + i), i == len - 1});
   endtask
   // Async reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic apply_reset;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_val", out_val, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_id", out_id, 0);
      check("rst_busy", busy, 0);
      check("rst_in_rdy", in_rdy, 0);
      check("rst_out_val3", out_val3, 0);
      @(negedge clk);
      in_val = '0;
      rst_n = 1'b1;
      model_reset();
   endtask
   task automatic step;
      obeat_t ob;
      logic [N-1:0] er;
      bit xfer, acc;
      @(negedge clk);
      cyc++;
      for (int r = 0; r < N; r++) begin
         in_val[r] = src[r].size() != 0 && $urandom_range(0, 99) < vprob;
         in_data[r*DW +: DW] = src[r].size() != 0 ? src[r][0].d : DW'($urandom);
         in_last[r] = src[r].size() != 0 ? src[r][0].l : 1'($urandom);
      end
      out_rdy = $urandom_range(0, 99) < rprob;
      #1;
      if (t_val < 0 && in_val != 0) t_val = cyc;
      if (t_out < 0 && out_val) t_out = cyc;
      er = '0;
      if (m_lock && (oq.size() == 0 || out_rdy)) er[m_own] = 1'b1;
      check("in_rdy", in_rdy, er);
      check("busy", busy, m_lock);
      check("out_val", out_val, oq.size() != 0);
      if (oq.size() != 0) begin
         check("out_data", out_data, oq[0].d);
         check("out_last", out_last, oq[0].l);
         check("out_id", out_id, oq[0].id);
      end
      xfer = oq.size() != 0 && out_rdy;
      acc = m_lock && in_val[m_own] && er[m_own];
      if (xfer) begin
         ob = oq.pop_front();
         ids.push_back(int'(ob.id));
      end
      if (acc) begin
         oq.push_back(obeat_t'{src[m_own][0].d, src[m_own][0].l, 2'(m_own)});
         src[m_own].delete(0);
         n_acc++;
         if (in_last[m_own]) begin
            m_lock = 1'b0;
            m_ptr = (m_own + 1) % N;
         end
      end else if (!m_lock && in_val != 0) begin
         for (int k = N - 1; k >= 0; k--) if (in_val[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
         m_lock = 1'b1;
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int exp37 [6] = '{0, 1, 2, 3, 0, 1};
      bit hit;
      in_val = '0; in_data = '0; in_last = '0; out_rdy = 1'b0;
      in_val3 = '0; in_data3 = '0; in_last3 = '0; out_rdy3 = 1'b1;
      model_reset();
      apply_reset();
      add_pkt(2, 3, 'hA1);
      repeat (10) step();
      check("latency", t_out - t_val, 2);
      check("single_n", ids.size(), 3);
      foreach (ids[i]) check("single_id", ids[i], 2);
      apply_reset();
      ids.delete();
      for (int r = 0; r < N; r++) for (int j = 0; j < 3; j++) add_pkt(r, 1, 16 * r + j);
      repeat (20) step();
      check("rr_n", ids.size() >= 6, 1);
      for (int i = 0; i < 6 && i < ids.size(); i++) check("rr_seq", ids[i], exp37[i]);
      apply_reset();
      add_pkt(3, 4, 'h30);
      n_acc = 0;
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         step();
         hit = n_acc == 2;
      end
      check("mid_pkt_reached", hit, 1);
      apply_reset();
      add_pkt(3, 2, 'h60);
      add_pkt(1, 2, 'h70);
      ids.delete();
      repeat (12) step();
      check("post_rst_n", ids.size() >= 1, 1);
      if (ids.size() != 0) check("post_rst_first", ids[0], 1);
      for (int round = 0; round < 40; round++) begin
         for (int r = 0; r < N; r++) if (src[r].size() < 3) add_pkt(r, $urandom_range(1, 4), $urandom);
         vprob = $urandom_range(40, 100);
         rprob = $urandom_range(30, 100);
         repeat (50) step();
         if (round % 13 == 7) apply_reset();
      end
      apply_reset();
      ids3.delete();
      in_val3 = 3'b110;
      in_last3 = 3'b111;
      in_data3 = 24'h22_11_00;
      repeat (24) begin
         @(negedge clk);
         #1;
         if (out_val3) ids3.push_back(int'(out_id3));
      end
      check("n3_count", ids3.size() >= 8, 1);
      foreach (ids3[i]) check("n3_id", ids3[i], (i % 2 == 0) ? 1 : 2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/rv_rr_arbiter.md
RV_RR_ARBITER -- requirements
Module: rv_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width per beat.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requester streams, legal range 2..16, need not be a power of two.
REQ-003 SHALL have input clk, 1 bit, clock, all state updates on rising edge.
REQ-004 SHALL have input rst_n, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have input in_data, NUM_REQ x DATA_WIDTH, per-requester payload.
REQ-006 SHALL have input in_val, NUM_REQ bits, per-requester valid.
REQ-007 SHALL have input in_last, NUM_REQ bits, per-requester end-of-packet marker.
REQ-008 SHALL have output in_rdy, NUM_REQ bits, per-requester ready.
REQ-009 SHALL have output out_data, DATA_WIDTH bits, registered merged payload.
REQ-010 SHALL have output out_last, 1 bit, registered end-of-packet.
REQ-011 SHALL have output out_id, $clog2(NUM_REQ) bits, registered source index of the current beat.
REQ-012 SHALL have output out_val, 1 bit, registered valid.
REQ-013 SHALL have input out_rdy, 1 bit, downstream ready, typically the in_rdy of a FIFO.
REQ-014 SHALL have output busy, 1 bit, high while a grant is locked.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and LOCK.
REQ-016 IDLE: with any in_val set, SHALL select the first requester with in_val set, searching from rr_ptr upward modulo NUM_REQ. It SHALL register the result as grant and move to LOCK on the next edge.
REQ-017 IDLE: SHALL hold all in_rdy at 0, giving one cycle of arbitration latency with no combinational val-to-rdy path.
REQ-018 LOCK: in_rdy[grant] SHALL equal (!out_val | out_rdy), and every other in_rdy bit SHALL be 0.
REQ-019 A beat SHALL be accepted when in_val[grant] & in_rdy[grant]. On acceptance, the output register SHALL load in_data[grant], in_last[grant] and grant, and out_val SHALL be set the next cycle.
REQ-020 out_val SHALL clear after an out_val & out_rdy transfer when no new beat is accepted in the same cycle.
REQ-021 The output register SHALL update on a simultaneous transfer and acceptance (full throughput, one beat per cycle in LOCK).
REQ-022 out_data, out_last and out_id SHALL hold stable while out_val & !out_rdy.
REQ-023 On an accepted beat with in_last[grant]=1, the block SHALL set rr_ptr to grant+1, wrapping NUM_REQ-1 to 0, and return to IDLE.
REQ-024 The previous winner SHALL be the lowest priority in the next arbitration.
REQ-025 in_val[grant] deasserting mid-packet SHALL NOT release the grant; the block SHALL remain in LOCK until a last beat is accepted.
REQ-026 A requester changing in_val in IDLE after the pick is registered SHALL NOT alter grant.
REQ-027 There SHALL be a minimum of one idle cycle between packets on the output (a one-cycle bubble after every last beat).
REQ-028 busy SHALL equal (state == LOCK).
REQ-029 rr_ptr and grant SHALL never hold a value >= NUM_REQ.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, rr_ptr 0, grant 0, out_val 0, out_last 0, out_id 0, out_data 0, in_rdy all 0.
REQ-031 Reset mid-packet SHALL discard the partial packet with no further output beats.
REQ-032 After reset release, the first arbitration SHALL start from requester 0.

Structure
REQ-033 Package rv_arb_pkg SHALL contain the state enum (IDLE, LOCK) and the default-parameter constants.
REQ-034 Combinational round-robin selection SHALL live in sub-module rr_pick, with inputs req vector and ptr and outputs idx and any.
REQ-035 The FSM, grant register and output register SHALL reside in rv_rr_arbiter.

Verification
REQ-036 Single requester: req 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), out_rdy=1 -> first out_val 2 cycles after in_val, 3 consecutive beats, out_id=2, out_last on 0xA3 only, then busy=0.
REQ-037 All 4 requesters hold 1-beat packets continuously after reset -> out_id sequence 0,1,2,3,0,1, with a one-cycle bubble between beats.
REQ-038 Backpressure: out_rdy=0 for 5 cycles mid-packet -> out_data/out_id unchanged, in_rdy[grant]=0, no beat lost or duplicated after out_rdy rises.
REQ-039 NUM_REQ=3, requesters 1 and 2 active, rr_ptr wraps -> grants alternate 1,2,1,2; out_id never reaches 3.
REQ-040 Granted requester drops in_val for 4 cycles mid-packet while requester 0 is valid -> busy stays 1, in_rdy[0]=0, packet resumes unchanged.
REQ-041 rst_n asserted during beat 2 of 4 -> all outputs 0 asynchronously; after release, the next grant goes to the lowest valid index.
